serial_rx: RTL and testbench

- UART receive front end feeding the loopback datapath.
- Oversamples the asynchronous FPGA serial RX pin and frames 8N1 characters, LSB first.
- Presents each received byte on a valid/ready handshake to the downstream transmit path.
- Flags framing errors and overruns.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_bit_timer.sv | 33 +++
 rtl/serial_rx.sv | 173 +++++++++++++++++
 tb/tb_serial_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit front end:
// default baud-rate timing, character width and the receiver FSM states.
package serial_pkg;

  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 9600;
  // Rounded to the nearest cycle: 10417 at 100 MHz / 9600 baud
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // 2-of-3 majority, used when the receiver votes on three samples per bit
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer shared by the UART receiver and transmitter.
// Down-counter reloaded by i_load (and automatically on terminal count).
// o_half_tick fires CLKS_PER_BIT/2 cycles after a load, o_full_tick fires
// CLKS_PER_BIT cycles after a load and then every CLKS_PER_BIT cycles.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_half_tick,
  output logic o_full_tick
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_VAL = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [CW-1:0] r_cnt;

  // Count down to zero, wrapping to a full period; load restarts the period
  always_ff @(posedge clk) begin
    if (rst || i_load || (r_cnt == '0)) begin
      r_cnt <= LOAD_VAL;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_half_tick = (r_cnt == HALF_VAL);
  assign o_full_tick = (r_cnt == '0);

endmodule

// File: rtl/serial_rx.sv
// UART receiver: 8N1, LSB first, valid/ready output handshake.
// Optional build macro SERIAL_RX_MAJORITY_VOTE_EN: decide each start, data
// and stop bit by a 2-of-3 vote around the bit centre (needs CLKS_PER_BIT>=8).
// Without it a single centre sample is used.
//
// state | meaning
// IDLE  | line idle, waiting for a start edge (s==0)
// START | validating the start bit at its centre
// DATA  | sampling 8 data bits at each bit centre
// STOP  | checking the stop bit; after a bad stop, waiting for s==1
module serial_rx #(
  parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
  parameter bit LINE_INVERT  = 1'b1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import serial_pkg::*;

  localparam logic IDLE_LVL = !LINE_INVERT;
  localparam int   BW       = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_half_tick;
  logic                   w_full_tick;
  logic                   w_load;
  logic                   w_bit;
  logic                   w_start_tick;
  logic                   w_bit_tick;

  rx_state_t              r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [BW-1:0]          r_bitcnt;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_brk;

  // Metastability chain on the asynchronous pin, preset to the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end
  end

  // Normalised line: idle=1, start=0 regardless of pin polarity
  assign w_s = r_sync[SYNC_STAGES-1] ^ LINE_INVERT;

  // Timer free-runs from the start edge; re-centred at the start-bit centre
  assign w_load = (r_state == IDLE) || ((r_state == START) && w_half_tick);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .o_half_tick(w_half_tick),
    .o_full_tick(w_full_tick)
  );

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;
  logic       r_tick_d;

  // Keep the two previous samples and delay the centre strobe by one cycle,
  // so the decision sees samples at centre-1, centre and centre+1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist   <= 2'b11;
      r_tick_d <= 1'b0;
    end else begin
      r_hist   <= {r_hist[0], w_s};
      r_tick_d <= (r_state == START) ? w_half_tick : (w_full_tick && !r_brk);
    end
  end

  assign w_bit        = maj3(w_s, r_hist[0], r_hist[1]);
  assign w_start_tick = r_tick_d;
  assign w_bit_tick   = r_tick_d;
`else
  assign w_bit        = w_s;
  assign w_start_tick = w_half_tick;
  assign w_bit_tick   = w_full_tick && !r_brk;
`endif

  // Receiver FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_start_tick) begin
            if (!w_bit) begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            r_shift  <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + BW'(1);
            if (r_bitcnt == BW'(DATA_BITS - 1)) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          if (r_brk) begin
            // Hold off until the line returns to idle so a break can't retrigger
            if (w_s) begin
              r_brk   <= 1'b0;
              r_state <= IDLE;
            end
          end else if (w_bit_tick) begin
            if (w_bit) begin
              // New byte wins over a same-edge consume; overrun only if unconsumed
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              if (r_rx_valid && !rx_ready) begin
                r_overrun <= 1'b1;
              end
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_brk       <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx (inverted line, 16 clocks per bit).
// Expected bytes and error counts come from what the bench transmits.
module tb_serial_rx;

  localparam int CPB  = 16;
  localparam bit LI   = 1'b1;
  localparam int SYNC = 2;
  // start edge -> rx_valid rise: 9.5 bit periods + sync stages + 1
  localparam int LAT  = (CPB * 19) / 2 + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  serial_rx #(
    .CLKS_PER_BIT(CPB),
    .LINE_INVERT (LI),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Monitor: accepted bytes, valid-rise times, strobe counts
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         fe_pulses = 0;
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid && !prev_valid) rise_q.push_back(cyc);
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (frame_err) fe_cycles <= fe_cycles + 1;
    if (frame_err && !prev_fe) fe_pulses <= fe_pulses + 1;
    prev_valid <= rx_valid;
    prev_fe    <= frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one logical bit (1 = idle/mark) for a full bit period
  task automatic drive_bit(input logic b);
    rx_in = b ^ LI;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good_stop);
    rx_in = !LI;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_in = !LI;
    rx_ready = 1'b1;
    wait_cyc(5);
    n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_single;
    int gb, rb, vc, fp, t0;
    gb = got_q.size(); rb = rise_q.size(); vc = valid_cycles; fp = fe_pulses;
    t0 = cyc;
    send_byte(8'h61, 1'b1);
    wait_cyc(20);
    n_checks++; if (got_q.size() - gb !== 1) begin n_errors++; $display("FAIL single_count got=%0d exp=1", got_q.size() - gb); end
    n_checks++; if (got_q.size() > gb && got_q[gb] !== 8'h61) begin n_errors++; $display("FAIL single_data got=%h exp=61", got_q[gb]); end
    n_checks++; if (valid_cycles - vc !== 1) begin n_errors++; $display("FAIL single_valid_width got=%0d exp=1", valid_cycles - vc); end
    n_checks++; if (fe_pulses - fp !== 0) begin n_errors++; $display("FAIL single_frame_err got=%0d exp=0", fe_pulses - fp); end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL single_overrun got=%b exp=0", overrun); end
    n_checks++;
    if (rise_q.size() <= rb || rise_q[rb] - t0 < LAT - 1 || rise_q[rb] - t0 > LAT + 2) begin
      n_errors++;
      $display("FAIL single_latency got=%0d exp=%0d..%0d", (rise_q.size() > rb) ? rise_q[rb] - t0 : -1, LAT - 1, LAT + 2);
    end
  endtask

  task automatic test_back_to_back;
    int gb, rb, sp;
    gb = got_q.size(); rb = rise_q.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_cyc(20);
    n_checks++; if (got_q.size() - gb !== 2) begin n_errors++; $display("FAIL b2b_count got=%0d exp=2", got_q.size() - gb); end
    n_checks++; if (got_q.size() > gb && got_q[gb] !== 8'hAA) begin n_errors++; $display("FAIL b2b_first got=%h exp=aa", got_q[gb]); end
    n_checks++; if (got_q.size() > gb + 1 && got_q[gb+1] !== 8'h55) begin n_errors++; $display("FAIL b2b_second got=%h exp=55", got_q[gb+1]); end
    sp = (rise_q.size() > rb + 1) ? rise_q[rb+1] - rise_q[rb] : -1;
    n_checks++; if (sp < 10 * CPB - 2 || sp > 10 * CPB + 2) begin n_errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", sp, 10 * CPB); end
  endtask

  // Start pulse shorter than half a bit must be rejected; busy clears at
  // the start-bit centre, i.e. half bit + sync delay after the pulse start
  task automatic test_glitch;
    int gb, vc;
    logic saw_busy;
    gb = got_q.size(); vc = valid_cycles;
    saw_busy = 1'b0;
    rx_in = LI;
    for (int k = 0; k < CPB / 2 + SYNC + 2; k++) begin
      if (k == 4) rx_in = !LI;
      wait_cyc(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    n_checks++; if (saw_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_clear got=%b exp=0", busy); end
    wait_cyc(3 * CPB);
    n_checks++; if (valid_cycles - vc !== 0) begin n_errors++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cycles - vc); end
    n_checks++; if (got_q.size() - gb !== 0) begin n_errors++; $display("FAIL glitch_no_byte got=%0d exp=0", got_q.size() - gb); end
  endtask

  task automatic test_frame_err;
    int gb, vc, fp, fc;
    gb = got_q.size(); vc = valid_cycles; fp = fe_pulses; fc = fe_cycles;
    send_byte(8'h3C, 1'b0);
    wait_cyc(CPB);
    n_checks++; if (fe_pulses - fp !== 1) begin n_errors++; $display("FAIL ferr_pulses got=%0d exp=1", fe_pulses - fp); end
    n_checks++; if (fe_cycles - fc !== 1) begin n_errors++; $display("FAIL ferr_width got=%0d exp=1", fe_cycles - fc); end
    n_checks++; if (valid_cycles - vc !== 0) begin n_errors++; $display("FAIL ferr_no_valid got=%0d exp=0", valid_cycles - vc); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ferr_idle got=%b exp=0", busy); end
    send_byte(8'h3C, 1'b1);
    wait_cyc(20);
    n_checks++; if (got_q.size() - gb !== 1) begin n_errors++; $display("FAIL ferr_recover_count got=%0d exp=1", got_q.size() - gb); end
    n_checks++; if (got_q.size() > gb && got_q[gb] !== 8'h3C) begin n_errors++; $display("FAIL ferr_recover_data got=%h exp=3c", got_q[gb]); end
    n_checks++; if (fe_pulses - fp !== 1) begin n_errors++; $display("FAIL ferr_recover_pulses got=%0d exp=1", fe_pulses - fp); end
  endtask

  // Random frames with random stop quality and gaps vs. a queue of expected bytes
  task automatic test_random;
    logic [7:0] exp_q[$];
    int gb, vc, fp, fe_exp, gap;
    logic [7:0] b;
    logic good;
    gb = got_q.size(); vc = valid_cycles; fp = fe_pulses; fe_exp = 0;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_byte(b, good);
      if (good) begin
        exp_q.push_back(b);
        gap = $urandom_range(0, 20);
      end else begin
        fe_exp++;
        gap = CPB + $urandom_range(0, 20);
      end
      wait_cyc(gap);
    end
    wait_cyc(20);
    n_checks++; if (got_q.size() - gb !== exp_q.size()) begin n_errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q.size() <= gb + i || got_q[gb+i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL rand_data[%0d] got=%h exp=%h", i, (got_q.size() > gb + i) ? got_q[gb+i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++; if (fe_pulses - fp !== fe_exp) begin n_errors++; $display("FAIL rand_frame_err got=%0d exp=%0d", fe_pulses - fp, fe_exp); end
    n_checks++; if (valid_cycles - vc !== exp_q.size()) begin n_errors++; $display("FAIL rand_valid_cycles got=%0d exp=%0d", valid_cycles - vc, exp_q.size()); end
  endtask

  task automatic test_overrun;
    int gb;
    gb = got_q.size();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    wait_cyc(5);
    send_byte(8'h22, 1'b1);
    wait_cyc(20);
    n_checks++; if (rx_data !== 8'h22) begin n_errors++; $display("FAIL ovr_data got=%h exp=22", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    rx_ready = 1'b1;
    wait_cyc(1);
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_consume got=%b exp=0", rx_valid); end
    n_checks++; if (got_q.size() - gb !== 1 || got_q[gb] !== 8'h22) begin n_errors++; $display("FAIL ovr_consumed_byte got=%h exp=22", (got_q.size() > gb) ? got_q[gb] : 8'hxx); end
    wait_cyc(10);
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_midframe;
    int gb, fp;
    gb = got_q.size(); fp = fe_pulses;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        wait_cyc(CPB * 5 + CPB / 2);
        rst = 1'b1;
        wait_cyc(2);
        n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_frame_err got=%b exp=0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        wait_cyc(CPB);
        rst = 1'b0;
      end
    join
    wait_cyc(5);
    send_byte(8'h0F, 1'b1);
    wait_cyc(20);
    n_checks++; if (got_q.size() - gb !== 1) begin n_errors++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size() - gb); end
    n_checks++; if (got_q.size() > gb && got_q[gb] !== 8'h0F) begin n_errors++; $display("FAIL rstmid_data got=%h exp=0f", got_q[gb]); end
    n_checks++; if (fe_pulses - fp !== 0) begin n_errors++; $display("FAIL rstmid_frame_err got=%0d exp=0", fe_pulses - fp); end
  endtask

  initial begin
    rst = 1'b1;
    rx_in = !LI;
    rx_ready = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_random;
    test_overrun;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
